mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Clocked, parametrised arbiter between N requesting pipeline ports (IF, MEM, later DMA/debug) and one single-port synchronous RAM. Grants one access per cycle by fixed priority or round-robin, tracks in-flight reads through a tag pipeline matched to the RAM read latency, and returns data with a per-port valid strobe. Ports flagged as instruction ports read `NOP_VALUE` whenever they have no valid data, so a stalled fetch injects a NOP. It sits between the pipeline stages and main RAM and replaces the combinational IF/MEM manager.

## Interface
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.
- `NPORTS`, 2: number of requesters, 2..8. Port 0 is IF by convention.
- `RD_LAT`, 1: RAM read latency in cycles, 1..4.
- `RR_MODE`, 0: 0 = fixed priority, highest index wins. 1 = round-robin.
- `NOP_MASK`, 1: bit i set means port i's `rdata` shows `NOP_VALUE` when not valid.
- `NOP_VALUE`, 0: instruction word substituted on NOP ports.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `req` in NPORTS: access request, one bit per port.
- `we` in NPORTS: write qualifier for `req`.
- `addr` in NPORTS*ADDR_W: flattened addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- `wdata` in NPORTS*DATA_W: flattened write data.
- `gnt` out NPORTS: combinational one-hot grant, or all-zero.
- `rvalid` out NPORTS: registered one-cycle read-return strobe.
- `rdata` out NPORTS*DATA_W: registered per-port read data.
- `ram_en` out 1: RAM access enable.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_W: RAM address.
- `ram_wdata` out DATA_W: RAM write data.
- `ram_rdata` in DATA_W: RAM read data, valid RD_LAT cycles after `ram_en` with `ram_we` low.

## Operation
- **Arbitration:** combinational, every cycle. `gnt` is one-hot among the `req` bits, or zero when `req` is zero.
- **Transaction:** an access completes when `req[i] & gnt[i]`. A requester holds `req`, `we`, `addr` and `wdata` stable until it is granted. Ungranted ports see `gnt[i]`=0 and stall.
- **Fixed priority (RR_MODE=0):** the highest-index requesting port wins, so MEM (1) beats IF (0).
- **Round-robin (RR_MODE=1):**
  - A pointer `ptr` (width clog2 NPORTS) selects the first port searched, then ptr+1, wrapping modulo NPORTS.
  - After a grant to port k, `ptr` becomes (k+1) mod NPORTS.
  - `ptr` is unchanged on idle cycles. Reset sets `ptr`=0.
- **RAM drive:**
  - `ram_en` = |(req&gnt).
  - `ram_we`, `ram_addr` and `ram_wdata` come from the winner's fields.
  - When idle, `ram_addr`/`ram_wdata` are 0.
- **Tag pipeline:**
  - An RD_LAT-deep shift register of {valid, port index}.
  - A granted read enters stage 0. Writes and idle cycles enter valid=0.
  - Any number of reads may be in flight, one per stage.
- **Return:** when the last stage holds valid with port p, on the next edge:
  - `rdata[p]` is loaded with `ram_rdata`;
  - `rvalid[p]` is 1 for exactly that cycle.
- **Idle ports:**
  - In cycles without a return to port i, `rvalid[i]`=0.
  - If `NOP_MASK[i]` is set, `rdata[i]` is forced to `NOP_VALUE`.
  - Otherwise `rdata[i]` holds its last returned value.
- **Writes:** complete on grant. They produce no `rvalid` and do not disturb in-flight reads.
- **Same-address access:** a read following a write to the same address in the next cycle returns the new data, because the RAM is write-first. The arbiter adds no forwarding.

## Timing
- **Grant:** `gnt` settles in the same cycle as `req`, with zero latency.
- **Read latency:** a read granted in cycle T gives `rvalid`/`rdata` high/valid in cycle T+RD_LAT+1. That is 2 cycles for RD_LAT=1.
- **Throughput:** one access per cycle, sustained, with back-to-back reads from different ports interleaved.
- **Reset values:**
  - `rvalid`=0 and `ptr`=0.
  - Tag pipeline all invalid.
  - `rdata[i]` = `NOP_VALUE` on NOP_MASK ports and 0 elsewhere.
  - Combinational outputs follow their inputs; `ram_en`=0 while `req`=0.
- **Reset mid-operation:** in-flight reads are discarded and no `rvalid` is raised for them after reset deasserts.
- **Simultaneous requests:** exactly one grant. A losing port keeps its request and is re-arbitrated the next cycle.
- **Starvation:** in RR_MODE=1, a port requesting continuously waits at most NPORTS-1 cycles. In RR_MODE=0, a low port can starve; that is accepted behaviour.

## Test plan
- **Reset:** NPORTS=2, RD_LAT=1. Reset mid-run with 2 reads in flight -> `rvalid`=0 throughout, `rdata[0]`=`NOP_VALUE` (0), `rdata[1]`=0, and no stray `rvalid` after release.
- **Fixed-priority conflict:** IF reads addr 0x0010 while MEM reads 0x0020 in the same cycle -> `gnt`=2'b10, `ram_addr`=0x0020, and IF is granted the next cycle. `rvalid[1]` arrives at T+2 with mem[0x20] and `rvalid[0]` at T+3 with mem[0x10]. `rdata[0]`=`NOP_VALUE` in between.
- **Write then read:** MEM writes 0xBEEF to 0x0005, then reads 0x0005 -> no `rvalid` for the write, and the read returns 0xBEEF two cycles after its grant.
- **Round-robin:** RR_MODE=1, NPORTS=4, all req held high for 8 cycles -> grants go 0,1,2,3,0,1,2,3, each port gets 2 `rvalid` pulses, and `ptr` wraps 3->0.
- **Pipelined reads:** RD_LAT=3, port 0 issues reads to 0x100..0x103 in 4 consecutive cycles -> 4 consecutive `rvalid[0]` pulses starting at T+4, with data in issue order.
- **Idle hold:** a non-NOP port (NOP_MASK=0) goes idle after reading 0x1234 -> `rdata` holds 0x1234 and `ram_en` stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between NPORTS pipeline
// requesters. Grants one access per cycle by fixed priority (highest index
// wins) or round-robin. In-flight reads are tracked by a tag pipeline whose
// depth matches the RAM read latency, and data comes back with a per-port
// valid strobe. Ports flagged in NOP_MASK show NOP_VALUE whenever no data
// returns, so a stalled instruction fetch sees a NOP.
module mem_arbiter #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter int                NPORTS    = 2,
    parameter int                RD_LAT    = 1,
    parameter int                RR_MODE   = 0,
    parameter logic [7:0]        NOP_MASK  = 8'h01,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        req,
    input  logic [NPORTS-1:0]        we,
    input  logic [NPORTS*ADDR_W-1:0] addr,
    input  logic [NPORTS*DATA_W-1:0] wdata,
    output logic [NPORTS-1:0]        gnt,
    output logic [NPORTS-1:0]        rvalid,
    output logic [NPORTS*DATA_W-1:0] rdata,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_wdata,
    input  logic [DATA_W-1:0]        ram_rdata
);

    localparam int PTR_W = $clog2(NPORTS);

    logic [ADDR_W-1:0] addr_a    [NPORTS];
    logic [DATA_W-1:0] wdata_a   [NPORTS];
    logic [DATA_W-1:0] rdata_q   [NPORTS];
    logic [DATA_W-1:0] rdata_d   [NPORTS];
    logic [NPORTS-1:0] rvalid_q;
    logic [NPORTS-1:0] rvalid_d;

    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  ptr_d;
    logic [PTR_W-1:0]  win;
    logic              any_req;

    logic [RD_LAT-1:0] tag_vld_q;
    logic [RD_LAT-1:0] tag_vld_d;
    logic [PTR_W-1:0]  tag_port_q [RD_LAT];
    logic [PTR_W-1:0]  tag_port_d [RD_LAT];

    logic              ret_vld;
    logic [PTR_W-1:0]  ret_port;

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
        assign addr_a[gi]                    = addr[gi*ADDR_W +: ADDR_W];
        assign wdata_a[gi]                   = wdata[gi*DATA_W +: DATA_W];
        assign rdata[gi*DATA_W +: DATA_W]    = rdata_q[gi];
    end

    assign rvalid = rvalid_q;

    // Select the winning port: highest index, or first requester from ptr on.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        if (RR_MODE != 0) begin
            // Walk backwards so the port closest to ptr is assigned last.
            for (int off = NPORTS - 1; off >= 0; off--) begin
                if (req[(int'(ptr_q) + off) % NPORTS]) begin
                    win     = PTR_W'((int'(ptr_q) + off) % NPORTS);
                    any_req = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (req[i]) begin
                    win     = PTR_W'(i);
                    any_req = 1'b1;
                end
            end
        end
    end

    // Drive grant and the RAM port from the winner's fields.
    always_comb begin
        gnt       = '0;
        ram_en    = any_req;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (any_req) begin
            gnt[win]  = 1'b1;
            ram_we    = we[win];
            ram_addr  = addr_a[win];
            ram_wdata = wdata_a[win];
        end
    end

    // Round-robin pointer advances past the last granted port; idle cycles hold it.
    always_comb begin
        ptr_d = ptr_q;
        if (any_req) begin
            ptr_d = (int'(win) == NPORTS - 1) ? '0 : win + 1'b1;
        end
    end

    // Tag pipeline: stage 0 takes the granted read, later stages shift along.
    always_comb begin
        tag_vld_d     = '0;
        for (int s = 0; s < RD_LAT; s++) begin
            tag_port_d[s] = '0;
        end
        tag_vld_d[0]  = any_req & ~we[win];
        tag_port_d[0] = win;
        for (int s = 1; s < RD_LAT; s++) begin
            tag_vld_d[s]  = tag_vld_q[s-1];
            tag_port_d[s] = tag_port_q[s-1];
        end
    end

    // Return path: load RAM data for the tagged port, otherwise NOP or hold.
    always_comb begin
        ret_vld  = tag_vld_q[RD_LAT-1];
        ret_port = tag_port_q[RD_LAT-1];
        rvalid_d = '0;
        for (int i = 0; i < NPORTS; i++) begin
            rvalid_d[i] = ret_vld && (ret_port == PTR_W'(i));
            if (rvalid_d[i]) begin
                rdata_d[i] = ram_rdata;
            end else if (NOP_MASK[i]) begin
                rdata_d[i] = NOP_VALUE;
            end else begin
                rdata_d[i] = rdata_q[i];
            end
        end
    end

    // State registers; reset drops every in-flight read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            tag_vld_q <= '0;
            rvalid_q  <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                tag_port_q[s] <= '0;
            end
            for (int i = 0; i < NPORTS; i++) begin
                rdata_q[i] <= NOP_MASK[i] ? NOP_VALUE : '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            tag_vld_q <= tag_vld_d;
            rvalid_q  <= rvalid_d;
            for (int s = 0; s < RD_LAT; s++) begin
                tag_port_q[s] <= tag_port_d[s];
            end
            for (int i = 0; i < NPORTS; i++) begin
                rdata_q[i] <= rdata_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (fixed priority RD_LAT=1,
// round-robin 4 ports, RD_LAT=3) each with a behavioural RAM, directed
// stimulus and a per-instance queue of expected read returns.
module tb_mem_arbiter;

    typedef struct {
        int          port;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;

    // Instance A: 2 ports, fixed priority, RD_LAT=1, port 0 NOP (value 0)
    logic [1:0]  a_req, a_we, a_gnt, a_rvalid;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_ram_en, a_ram_we;
    logic [15:0] a_ram_addr, a_ram_wdata, a_ram_rdata;

    // Instance B: 4 ports, round-robin, RD_LAT=1, no NOP ports
    logic [3:0]  b_req, b_we, b_gnt, b_rvalid;
    logic [63:0] b_addr, b_wdata, b_rdata;
    logic        b_ram_en, b_ram_we;
    logic [15:0] b_ram_addr, b_ram_wdata, b_ram_rdata;

    // Instance C: 2 ports, fixed priority, RD_LAT=3, port 0 NOP value 0x0013
    logic [1:0]  c_req, c_we, c_gnt, c_rvalid;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        c_ram_en, c_ram_we;
    logic [15:0] c_ram_addr, c_ram_wdata, c_ram_rdata;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .NPORTS(2), .RD_LAT(1), .RR_MODE(0),
                  .NOP_MASK(8'h01), .NOP_VALUE(16'h0000)) dut_a (
        .clk(clk), .reset(reset), .req(a_req), .we(a_we), .addr(a_addr),
        .wdata(a_wdata), .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata),
        .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
        .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata));

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .NPORTS(4), .RD_LAT(1), .RR_MODE(1),
                  .NOP_MASK(8'h00), .NOP_VALUE(16'h0000)) dut_b (
        .clk(clk), .reset(reset), .req(b_req), .we(b_we), .addr(b_addr),
        .wdata(b_wdata), .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata));

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .NPORTS(2), .RD_LAT(3), .RR_MODE(0),
                  .NOP_MASK(8'h01), .NOP_VALUE(16'h0013)) dut_c (
        .clk(clk), .reset(reset), .req(c_req), .we(c_we), .addr(c_addr),
        .wdata(c_wdata), .gnt(c_gnt), .rvalid(c_rvalid), .rdata(c_rdata),
        .ram_en(c_ram_en), .ram_we(c_ram_we), .ram_addr(c_ram_addr),
        .ram_wdata(c_ram_wdata), .ram_rdata(c_ram_rdata));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Unwritten RAM locations hold a fixed function of their address.
    function automatic logic [15:0] f(input logic [15:0] a);
        return a ^ 16'hC3C3;
    endfunction

    // Behavioural write-first RAMs with the matching read latency.
    logic [15:0] wm_a [int];
    logic [15:0] wm_b [int];
    logic [15:0] wm_c [int];
    logic [15:0] c_p0, c_p1, c_p2;

    always @(posedge clk) begin
        if (a_ram_en) begin
            if (a_ram_we) wm_a[int'(a_ram_addr)] = a_ram_wdata;
            else a_ram_rdata <= wm_a.exists(int'(a_ram_addr)) ? wm_a[int'(a_ram_addr)] : f(a_ram_addr);
        end
    end

    always @(posedge clk) begin
        if (b_ram_en) begin
            if (b_ram_we) wm_b[int'(b_ram_addr)] = b_ram_wdata;
            else b_ram_rdata <= wm_b.exists(int'(b_ram_addr)) ? wm_b[int'(b_ram_addr)] : f(b_ram_addr);
        end
    end

    always @(posedge clk) begin
        if (c_ram_en) begin
            if (c_ram_we) wm_c[int'(c_ram_addr)] = c_ram_wdata;
            else c_p0 <= wm_c.exists(int'(c_ram_addr)) ? wm_c[int'(c_ram_addr)] : f(c_ram_addr);
        end
        c_p1 <= c_p0;
        c_p2 <= c_p1;
    end
    assign c_ram_rdata = c_p2;

    int   n_checks;
    int   n_errors;
    int   cyc_n;
    int   cnt_b [4];
    exp_t qa [$];
    exp_t qb [$];
    exp_t qc [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int d, input int p, input logic [15:0] data, input int lat);
        exp_t e;
        e.port = p;
        e.data = data;
        e.cyc  = cyc_n + lat + 1;
        case (d)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic sb_port(input int d, input int p, input logic rv, input logic [15:0] rd);
        exp_t e;
        int   sz;
        if (rv) begin
            if (d == 1) cnt_b[p]++;
            sz = (d == 0) ? qa.size() : (d == 1) ? qb.size() : qc.size();
            chk($sformatf("sb%0d_rvalid_expected_p%0d", d, p), 64'(sz != 0), 64'd1);
            if (sz != 0) begin
                if (d == 0)      e = qa.pop_front();
                else if (d == 1) e = qb.pop_front();
                else             e = qc.pop_front();
                chk($sformatf("sb%0d_port", d), 64'(p), 64'(e.port));
                chk($sformatf("sb%0d_data_p%0d", d, p), 64'(rd), 64'(e.data));
                chk($sformatf("sb%0d_cycle_p%0d", d, p), 64'(cyc_n), 64'(e.cyc));
            end
        end
    endtask

    task automatic sb_check();
        for (int p = 0; p < 2; p++) sb_port(0, p, a_rvalid[p], a_rdata[p*16 +: 16]);
        for (int p = 0; p < 4; p++) sb_port(1, p, b_rvalid[p], b_rdata[p*16 +: 16]);
        for (int p = 0; p < 2; p++) sb_port(2, p, c_rvalid[p], c_rdata[p*16 +: 16]);
    endtask

    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        sb_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ta;
        int          rr_exp [3];
        n_checks = 0;
        n_errors = 0;
        cyc_n    = 0;
        for (int i = 0; i < 4; i++) cnt_b[i] = 0;
        reset = 1'b1;
        a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0;
        b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
        c_req = '0; c_we = '0; c_addr = '0; c_wdata = '0;
        repeat (2) @(negedge clk);

        chk("rst_a_rvalid", 64'(a_rvalid), 64'd0);
        chk("rst_a_rdata", 64'(a_rdata), 64'd0);
        chk("rst_a_ram_en", 64'(a_ram_en), 64'd0);
        chk("rst_b_gnt", 64'(b_gnt), 64'd0);
        chk("rst_c_rdata", 64'(c_rdata), 64'h0000_0013);
        reset = 1'b0;
        cyc();

        // Fixed-priority conflict: MEM (1) wins, IF (0) follows next cycle
        a_req  = 2'b11;
        a_addr = {16'h0020, 16'h0010};
        #1;
        chk("fp_gnt", 64'(a_gnt), 64'h2);
        chk("fp_ram_addr", 64'(a_ram_addr), 64'h0020);
        chk("fp_ram_en", 64'(a_ram_en), 64'd1);
        push(0, 1, f(16'h0020), 1);
        cyc();
        a_req = 2'b01;
        #1;
        chk("fp_gnt_if", 64'(a_gnt), 64'h1);
        chk("fp_ram_addr_if", 64'(a_ram_addr), 64'h0010);
        push(0, 0, f(16'h0010), 1);
        cyc();
        a_req = 2'b00;
        #1;
        chk("fp_rvalid_t2", 64'(a_rvalid), 64'h2);
        chk("fp_nop_between", 64'(a_rdata[15:0]), 64'h0);
        chk("idle_ram_en", 64'(a_ram_en), 64'd0);
        chk("idle_ram_addr", 64'(a_ram_addr), 64'd0);
        chk("idle_gnt", 64'(a_gnt), 64'd0);
        cyc();
        chk("fp_rvalid_t3", 64'(a_rvalid), 64'h1);
        cyc();
        chk("fp_rvalid_t4", 64'(a_rvalid), 64'h0);
        chk("fp_nop_after", 64'(a_rdata[15:0]), 64'h0);

        // Write then read of the same address from MEM
        a_req   = 2'b10;
        a_we    = 2'b10;
        a_addr  = {16'h0005, 16'h0000};
        a_wdata = {16'hBEEF, 16'h0000};
        #1;
        chk("wr_gnt", 64'(a_gnt), 64'h2);
        chk("wr_ram_we", 64'(a_ram_we), 64'd1);
        chk("wr_ram_addr", 64'(a_ram_addr), 64'h0005);
        chk("wr_ram_wdata", 64'(a_ram_wdata), 64'hBEEF);
        cyc();
        a_we = 2'b00;
        #1;
        chk("rd_ram_we", 64'(a_ram_we), 64'd0);
        push(0, 1, 16'hBEEF, 1);
        cyc();
        a_req = 2'b00;
        chk("wr_no_rvalid", 64'(a_rvalid), 64'd0);
        cyc();
        cyc();

        // Idle hold on the non-NOP port
        a_req  = 2'b10;
        a_addr = {16'h1234, 16'h0000};
        #1;
        push(0, 1, f(16'h1234), 1);
        cyc();
        a_req = 2'b00;
        cyc();
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("hold_rdata1", 64'(a_rdata[31:16]), 64'(f(16'h1234)));
            chk("hold_ram_en", 64'(a_ram_en), 64'd0);
        end

        // Round-robin: all four ports request for 8 cycles
        b_req  = 4'hF;
        b_addr = {16'h0203, 16'h0202, 16'h0201, 16'h0200};
        for (int k = 0; k < 8; k++) begin
            ta = 16'h0200 + 16'(k % 4);
            #1;
            chk($sformatf("rr_gnt_%0d", k), 64'(b_gnt), 64'd1 << (k % 4));
            chk($sformatf("rr_addr_%0d", k), 64'(b_ram_addr), 64'(ta));
            push(1, k % 4, f(ta), 1);
            cyc();
        end
        b_req = 4'h0;
        repeat (3) cyc();
        for (int p = 0; p < 4; p++) chk($sformatf("rr_pulses_p%0d", p), 64'(cnt_b[p]), 64'd2);

        // Round-robin with a sparse request set: pointer skips idle ports and wraps
        rr_exp = '{1, 3, 1};
        b_req  = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            ta = 16'h0200 + 16'(rr_exp[k]);
            #1;
            chk($sformatf("rr_sparse_gnt_%0d", k), 64'(b_gnt), 64'd1 << rr_exp[k]);
            push(1, rr_exp[k], f(ta), 1);
            cyc();
        end
        b_req = 4'h0;
        repeat (3) cyc();

        // RD_LAT=3: four back-to-back reads, then a write and read from port 1
        c_req = 2'b01;
        for (int k = 0; k < 4; k++) begin
            ta     = 16'h0100 + 16'(k);
            c_addr = {16'h0000, ta};
            #1;
            chk($sformatf("pl_gnt_%0d", k), 64'(c_gnt), 64'h1);
            push(2, 0, f(ta), 3);
            cyc();
        end
        c_req   = 2'b10;
        c_we    = 2'b10;
        c_addr  = {16'h0100, 16'h0000};
        c_wdata = {16'h5555, 16'h0000};
        #1;
        chk("pl_wr_gnt", 64'(c_gnt), 64'h2);
        cyc();
        c_we = 2'b00;
        #1;
        push(2, 1, 16'h5555, 3);
        cyc();
        c_req = 2'b00;
        repeat (6) cyc();
        chk("pl_nop_after", 64'(c_rdata[15:0]), 64'h0013);

        // Reset with two reads in flight
        a_req  = 2'b10;
        a_addr = {16'h0030, 16'h0040};
        #1;
        chk("rm_gnt1", 64'(a_gnt), 64'h2);
        cyc();
        a_req = 2'b01;
        #1;
        chk("rm_gnt0", 64'(a_gnt), 64'h1);
        reset = 1'b1;
        a_req = 2'b00;
        #1;
        chk("rm_rvalid", 64'(a_rvalid), 64'd0);
        chk("rm_rdata", 64'(a_rdata), 64'd0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("rm_rvalid_held", 64'(a_rvalid), 64'd0);
            chk("rm_rdata_held", 64'(a_rdata), 64'd0);
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("rm_no_stray", 64'(a_rvalid), 64'd0);
        end

        chk("qa_drained", 64'(qa.size()), 64'd0);
        chk("qb_drained", 64'(qb.size()), 64'd0);
        chk("qc_drained", 64'(qc.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
